mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 mux datapath among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 116 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the selects of an integrated 4:1 mux.
// The grant, the selects and valid are registered; y follows the inputs combinationally.
module mux4_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   output logic [3:0]       gnt,
   output logic             s1,
   output logic             s0,
   output logic             valid,
   output logic [WIDTH-1:0] y
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q;
   logic [3:0]    gnt_q;
   logic [1:0]    sel_q;
   logic          valid_q;
   logic [1:0]    ptr_q;
   logic [HW-1:0] hold_q;

   logic [3:0]    others;
   logic [1:0]    win_idx;
   logic          grant_new;
   logic          go_idle;
   logic          hold_at_sat;

   // First set bit of r scanning start, start+1, ... (mod 4); returns start when r is zero.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] idx;
      pick = start;
      for (int j = 3; j >= 0; j--) begin
         idx = start + 2'(j);
         if (r[idx]) pick = idx;
      end
   endfunction

   assign hold_at_sat = (MAX_HOLD != 0) && (hold_q == HOLD_SAT);

   always_comb begin
      others    = req & ~(4'b0001 << sel_q);
      win_idx   = pick(req, ptr_q);
      grant_new = 1'b0;
      go_idle   = 1'b0;
      case (state_q)
         IDLE: grant_new = |req;
         GRANT: begin
            // The owner never competes with itself: search the others from owner+1.
            win_idx = pick(others, sel_q + 2'd1);
            if (!req[sel_q]) begin
               grant_new = |others;
               go_idle   = ~|others;
            end else if (hold_at_sat && |others) begin
               grant_new = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         valid_q <= 1'b0;
         ptr_q   <= 2'd0;
         hold_q  <= '0;
      end else if (grant_new) begin
         state_q <= GRANT;
         gnt_q   <= 4'b0001 << win_idx;
         sel_q   <= win_idx;
         valid_q <= 1'b1;
         ptr_q   <= win_idx + 2'd1;
         hold_q  <= '0;
      end else if (go_idle) begin
         // Selects keep their last value while idle.
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         valid_q <= 1'b0;
      end else if (state_q == GRANT && MAX_HOLD != 0 && !hold_at_sat) begin
         hold_q  <= hold_q + HW'(1);
      end
   end

   logic [WIDTH-1:0] mux_out;

   always_comb begin
      mux_out = '0;
      case (sel_q)
         2'd0: mux_out = i0;
         2'd1: mux_out = i1;
         2'd2: mux_out = i2;
         2'd3: mux_out = i3;
         default: mux_out = '0;
      endcase
   end

   assign gnt   = gnt_q;
   assign s1    = sel_q[1];
   assign s0    = sel_q[0];
   assign valid = valid_q;
   assign y     = valid_q ? mux_out : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=4, MAX_HOLD=4) with hand-computed expectations.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] i0, i1, i2, i3;
   logic [3:0] gnt;
   logic       s1, s0, valid;
   logic [3:0] y;

   int n_chk  = 0;
   int n_pass = 0;

   mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3),
      .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .y(y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic chk_st(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                         input logic e_vld, input logic [3:0] e_y);
      chk({tag, "/gnt"},   32'(gnt),      32'(e_gnt));
      chk({tag, "/sel"},   32'({s1, s0}), 32'(e_sel));
      chk({tag, "/valid"}, 32'(valid),    32'(e_vld));
      chk({tag, "/y"},     32'(y),        32'(e_y));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] dat [4];
   int         order [5];

   initial begin
      dat[0] = 4'hA; dat[1] = 4'h5; dat[2] = 4'h1; dat[3] = 4'hC;
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
      i0 = dat[0]; i1 = dat[1]; i2 = dat[2]; i3 = dat[3];
      rst = 1'b1;
      req = 4'hF;

      // Reset holds everything at zero even with every source requesting.
      tick; chk_st("rst0", 4'b0000, 2'd0, 1'b0, 4'h0);
      tick; chk_st("rst1", 4'b0000, 2'd0, 1'b0, 4'h0);

      // Single requester, one-cycle latency, then back to idle with selects retained.
      rst = 1'b0; req = 4'b0100;
      tick; chk_st("single", 4'b0100, 2'd2, 1'b1, 4'h1);
      req = 4'b0000;
      tick; chk_st("idle", 4'b0000, 2'd2, 1'b0, 4'h0);

      // All requesting from ptr=0: 0,1,2,3,0 each for exactly 4 cycles.
      rst = 1'b1; req = 4'b0000;
      tick;
      rst = 1'b0; req = 4'hF;
      for (int g = 0; g < 5; g++)
         for (int c = 0; c < 4; c++) begin
            tick;
            chk_st($sformatf("rr%0d_%0d", g, c), 4'b0001 << order[g], 2'(order[g]), 1'b1,
                   dat[order[g]]);
         end
      // Owner 0 at saturation rotates to 1.
      tick; chk_st("rot1", 4'b0010, 2'd1, 1'b1, dat[1]);

      // Owner 1 drops while source 3 waits: direct handover, no bubble.
      req = 4'b1000;
      tick; chk_st("handover", 4'b1000, 2'd3, 1'b1, dat[3]);

      // Sole requester 2 keeps the grant for 10 cycles.
      req = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         tick; chk_st($sformatf("sole%0d", c), 4'b0100, 2'd2, 1'b1, dat[2]);
      end
      // Data path follows the input without a clock edge.
      i2 = 4'h7; #1;
      chk("y_comb", 32'(y), 32'h7);
      i2 = dat[2];
      // Requester 0 appears at saturation: forced rotation on the next edge.
      req = 4'b0101;
      tick; chk_st("preempt", 4'b0001, 2'd0, 1'b1, dat[0]);

      // Owner 0 drops, source 3 takes over; then reset mid-grant.
      req = 4'b1000;
      tick; chk_st("own3", 4'b1000, 2'd3, 1'b1, dat[3]);
      rst = 1'b1;
      tick; chk_st("midrst", 4'b0000, 2'd0, 1'b0, 4'h0);
      rst = 1'b0; req = 4'hF;
      tick; chk_st("postrst", 4'b0001, 2'd0, 1'b1, dat[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
